// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - MEM-stage load/store sequencer for the data-side SRAM-like bus.
// Optional alignment check guarded by MEM_ADDR_CHECK_EN.
module mem_req_ctrl #(
    parameter int RFDTL_W = 7,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_we,
    input  logic [1:0]         in_size,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_wdata,
    input  logic               in_unalign_ok,
    input  logic [RFDTL_W-1:0] in_rfdtl,
    input  logic               flush,
    output logic               data_req,
    output logic               data_wr,
    output logic [1:0]         data_size,
    output logic [31:0]        data_addr,
    output logic [31:0]        data_wdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic [31:0]        data_rdata,
    output logic               out_valid,
    input  logic               out_allow,
    output logic [31:0]        out_rdata,
    output logic [RFDTL_W-1:0] out_rfdtl,
    output logic [1:0]         out_ea,
    output logic               out_is_store,
`ifdef MEM_ADDR_CHECK_EN
    output logic               out_ex,
    output logic [31:0]        out_badvaddr,
`endif
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic                 discard_q, discard_d;
    logic                 data_req_q, data_req_d;
    logic                 data_wr_q, data_wr_d;
    logic [1:0]           data_size_q, data_size_d;
    logic [31:0]          data_addr_q, data_addr_d;
    logic [31:0]          data_wdata_q, data_wdata_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_rdata_q, out_rdata_d;
    logic [RFDTL_W-1:0]   out_rfdtl_q, out_rfdtl_d;
    logic [1:0]           out_ea_q, out_ea_d;
    logic                 out_is_store_q, out_is_store_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 accept;
    logic                 misalign;
`ifdef MEM_ADDR_CHECK_EN
    logic                 out_ex_q, out_ex_d;
    logic [31:0]          out_badvaddr_q, out_badvaddr_d;
`else
    logic                 unused_unalign_ok;
    assign unused_unalign_ok = in_unalign_ok;
`endif

    assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && out_allow));
    assign accept   = in_valid && in_ready;

`ifdef MEM_ADDR_CHECK_EN
    assign misalign = (in_size == 2'd1 && in_addr[0]) ||
                      (in_size == 2'd2 && in_addr[1:0] != 2'd0 && !in_unalign_ok);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        discard_d      = discard_q;
        data_wr_d      = data_wr_q;
        data_size_d    = data_size_q;
        data_addr_d    = data_addr_q;
        data_wdata_d   = data_wdata_q;
        out_rdata_d    = out_rdata_q;
        out_rfdtl_d    = out_rfdtl_q;
        out_ea_d       = out_ea_q;
        out_is_store_d = out_is_store_q;
        stall_cnt_d    = stall_cnt_q;
`ifdef MEM_ADDR_CHECK_EN
        out_ex_d       = out_ex_q;
        out_badvaddr_d = out_badvaddr_q;
`endif

        case (state_q)
            IDLE: ;
            REQ: begin
                // A flushed request is still carried to completion so the bus stays in sync.
                if (flush)        discard_d = 1'b1;
                if (data_addr_ok) state_d   = WAIT;
            end
            WAIT: begin
                if (flush) discard_d = 1'b1;
                if (data_data_ok) begin
                    if (discard_q || flush) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d     = DONE;
                        out_rdata_d = data_wr_q ? 32'd0 : data_rdata;
                    end
                end
            end
            DONE: begin
                if (flush || out_allow) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible from IDLE or a draining DONE, so it overrides the case result.
        if (accept) begin
            state_d        = misalign ? DONE : REQ;
            data_wr_d      = in_we;
            data_size_d    = in_size;
            data_addr_d    = in_addr;
            data_wdata_d   = in_wdata;
            out_rfdtl_d    = in_rfdtl;
            out_ea_d       = in_addr[1:0];
            out_is_store_d = in_we;
`ifdef MEM_ADDR_CHECK_EN
            out_ex_d       = misalign;
            out_badvaddr_d = misalign ? in_addr : 32'd0;
            if (misalign) out_rdata_d = 32'd0;
`endif
        end

        if ((state_q == REQ || state_q == WAIT) && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;

        data_req_d  = (state_d == REQ);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            discard_q      <= 1'b0;
            data_req_q     <= 1'b0;
            data_wr_q      <= 1'b0;
            data_size_q    <= 2'd0;
            data_addr_q    <= 32'd0;
            data_wdata_q   <= 32'd0;
            out_valid_q    <= 1'b0;
            out_rdata_q    <= 32'd0;
            out_rfdtl_q    <= '0;
            out_ea_q       <= 2'd0;
            out_is_store_q <= 1'b0;
            stall_cnt_q    <= '0;
`ifdef MEM_ADDR_CHECK_EN
            out_ex_q       <= 1'b0;
            out_badvaddr_q <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            discard_q      <= discard_d;
            data_req_q     <= data_req_d;
            data_wr_q      <= data_wr_d;
            data_size_q    <= data_size_d;
            data_addr_q    <= data_addr_d;
            data_wdata_q   <= data_wdata_d;
            out_valid_q    <= out_valid_d;
            out_rdata_q    <= out_rdata_d;
            out_rfdtl_q    <= out_rfdtl_d;
            out_ea_q       <= out_ea_d;
            out_is_store_q <= out_is_store_d;
            stall_cnt_q    <= stall_cnt_d;
`ifdef MEM_ADDR_CHECK_EN
            out_ex_q       <= out_ex_d;
            out_badvaddr_q <= out_badvaddr_d;
`endif
        end
    end

    assign data_req     = data_req_q;
    assign data_wr      = data_wr_q;
    assign data_size    = data_size_q;
    assign data_addr    = data_addr_q;
    assign data_wdata   = data_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_rdata    = out_rdata_q;
    assign out_rfdtl    = out_rfdtl_q;
    assign out_ea       = out_ea_q;
    assign out_is_store = out_is_store_q;
    assign stall_cnt    = stall_cnt_q;
`ifdef MEM_ADDR_CHECK_EN
    assign out_ex       = out_ex_q;
    assign out_badvaddr = out_badvaddr_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, in_we, in_unalign_ok, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [6:0]  in_rfdtl;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        out_valid, out_allow, out_is_store;
    logic [31:0] out_rdata;
    logic [6:0]  out_rfdtl;
    logic [1:0]  out_ea;
    logic [15:0] stall_cnt;
`ifdef MEM_ADDR_CHECK_EN
    logic        out_ex;
    logic [31:0] out_badvaddr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.RFDTL_W(7), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_unalign_ok(in_unalign_ok),
        .in_rfdtl(in_rfdtl), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .out_valid(out_valid), .out_allow(out_allow), .out_rdata(out_rdata),
        .out_rfdtl(out_rfdtl), .out_ea(out_ea), .out_is_store(out_is_store),
`ifdef MEM_ADDR_CHECK_EN
        .out_ex(out_ex), .out_badvaddr(out_badvaddr),
`endif
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [6:0] rfdtl);
        in_valid = 1'b1; in_we = we; in_size = size; in_addr = addr;
        in_wdata = wdata; in_rfdtl = rfdtl;
    endtask

    initial begin
        resetn = 1'b0; in_valid = 0; in_we = 0; in_size = 0; in_addr = 0; in_wdata = 0;
        in_unalign_ok = 0; in_rfdtl = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0;
        data_rdata = 0; out_allow = 0;
        tick(); tick();
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        resetn = 1'b1;
        #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // lw 0x1000_0004, zero-wait bus
        issue(1'b0, 2'd2, 32'h1000_0004, 32'd0, 7'h10);
        tick(); in_valid = 0;
        chk("lw_req", {31'd0, data_req}, 32'd1);
        chk("lw_addr", data_addr, 32'h1000_0004);
        chk("lw_size", {30'd0, data_size}, 32'd2);
        chk("lw_wr", {31'd0, data_wr}, 32'd0);
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        chk("lw_wait_req", {31'd0, data_req}, 32'd0);
        chk("lw_wait_valid", {31'd0, out_valid}, 32'd0);
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        tick(); data_data_ok = 0; data_rdata = 32'h0;
        chk("lw_valid", {31'd0, out_valid}, 32'd1);
        chk("lw_rdata", out_rdata, 32'hDEAD_BEEF);
        chk("lw_ea", {30'd0, out_ea}, 32'd0);
        chk("lw_rfdtl", {25'd0, out_rfdtl}, 32'h10);
        chk("lw_store", {31'd0, out_is_store}, 32'd0);
        chk("lw_stall", {16'd0, stall_cnt}, 32'd2);

        // hold in DONE for 3 cycles without out_allow
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_rdata", out_rdata, 32'hDEAD_BEEF);
        end

        // back-to-back: lb 0x1000_0003 accepted while DONE drains
        out_allow = 1;
        issue(1'b0, 2'd0, 32'h1000_0003, 32'd0, 7'h01);
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); in_valid = 0; out_allow = 0;
        chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("lb_req_held", {31'd0, data_req}, 32'd1);
            chk("lb_addr_held", data_addr, 32'h1000_0003);
            chk("lb_size_held", {30'd0, data_size}, 32'd0);
            if (i == 4) data_addr_ok = 1;
            tick();
        end
        data_addr_ok = 0;
        chk("lb_wait_req", {31'd0, data_req}, 32'd0);
        data_data_ok = 1; data_rdata = 32'h1122_3344;
        tick(); data_data_ok = 0;
        chk("lb_valid", {31'd0, out_valid}, 32'd1);
        chk("lb_rdata", out_rdata, 32'h1122_3344);
        chk("lb_ea", {30'd0, out_ea}, 32'd3);
        chk("lb_stall", {16'd0, stall_cnt}, 32'd8);
        out_allow = 1;
        tick(); out_allow = 0;
        chk("lb_idle", {31'd0, out_valid}, 32'd0);

        // data_data_ok in IDLE is ignored
        data_data_ok = 1; data_rdata = 32'h5555_0000;
        tick(); data_data_ok = 0;
        chk("stray_ok_valid", {31'd0, out_valid}, 32'd0);

        // sw 0x2000_0000
        issue(1'b1, 2'd2, 32'h2000_0000, 32'h1234_5678, 7'h00);
        tick(); in_valid = 0;
        chk("sw_wr", {31'd0, data_wr}, 32'd1);
        chk("sw_wdata", data_wdata, 32'h1234_5678);
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
        tick(); data_data_ok = 0;
        chk("sw_valid", {31'd0, out_valid}, 32'd1);
        chk("sw_store", {31'd0, out_is_store}, 32'd1);
        chk("sw_rdata", out_rdata, 32'd0);
        chk("sw_stall", {16'd0, stall_cnt}, 32'd10);
        out_allow = 1;
        tick(); out_allow = 0;

        // flush during WAIT discards the response
        issue(1'b0, 2'd2, 32'h1000_0008, 32'd0, 7'h10);
        tick(); in_valid = 0;
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        flush = 1;
        tick(); flush = 0;
        data_data_ok = 1; data_rdata = 32'hAAAA_5555;
        tick(); data_data_ok = 0;
        chk("flw_valid", {31'd0, out_valid}, 32'd0);
        #1 chk("flw_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flw_stall", {16'd0, stall_cnt}, 32'd13);
        tick();
        chk("flw_valid2", {31'd0, out_valid}, 32'd0);
        issue(1'b0, 2'd2, 32'h1000_000C, 32'd0, 7'h10);
        tick(); in_valid = 0;
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
        tick(); data_data_ok = 0;
        chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
        chk("post_flush_rdata", out_rdata, 32'h0BAD_F00D);

        // flush in DONE drops out_valid
        flush = 1;
        tick();
        chk("fdone_valid", {31'd0, out_valid}, 32'd0);

        // flush with in_valid in IDLE blocks the accept
        issue(1'b0, 2'd2, 32'h1000_0010, 32'd0, 7'h10);
        #1 chk("fin_in_ready", {31'd0, in_ready}, 32'd0);
        tick(); in_valid = 0; flush = 0;
        chk("fin_no_req", {31'd0, data_req}, 32'd0);

        // flush in REQ keeps the request up, response is dropped
        issue(1'b0, 2'd2, 32'h1000_0014, 32'd0, 7'h10);
        tick(); in_valid = 0;
        flush = 1;
        tick(); flush = 0;
        chk("freq_req_held", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h7777_7777;
        tick(); data_data_ok = 0;
        chk("freq_valid", {31'd0, out_valid}, 32'd0);

        // reset mid-transaction
        issue(1'b0, 2'd2, 32'h1000_0018, 32'd0, 7'h10);
        tick(); in_valid = 0;
        resetn = 0;
        #1;
        chk("mrst_req", {31'd0, data_req}, 32'd0);
        chk("mrst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("mrst_addr", data_addr, 32'd0);
        tick(); resetn = 1;

`ifdef MEM_ADDR_CHECK_EN
        issue(1'b0, 2'd1, 32'h3000_0001, 32'd0, 7'h02);
        tick(); in_valid = 0;
        chk("mis_no_req", {31'd0, data_req}, 32'd0);
        chk("mis_valid", {31'd0, out_valid}, 32'd1);
        chk("mis_ex", {31'd0, out_ex}, 32'd1);
        chk("mis_badv", out_badvaddr, 32'h3000_0001);
        out_allow = 1;
        tick(); out_allow = 0;
        in_unalign_ok = 1;
        issue(1'b0, 2'd2, 32'h3000_0002, 32'd0, 7'h40);
        tick(); in_valid = 0; in_unalign_ok = 0;
        chk("lwl_req", {31'd0, data_req}, 32'd1);
        chk("lwl_addr", data_addr, 32'h3000_0002);
        chk("lwl_ex", {31'd0, out_ex}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
